// File: rtl/vector_register_reader.sv
// ----------------------------------------------------------------------------
// vector_register_reader
//
// Read-side streamer for the vector register file. A request names a vector
// register and an element count. The block then reads elements 0..vlen-1
// through the register file's 1-cycle-latency read port. It presents them in
// ascending order, one per cycle, on a valid/ready element stream toward the
// execution lanes.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake
//   req_vreg, req_vlen         register to read, element count (0..DEPTH)
//   rf_rd_en                   register file read strobe
//   rf_rd_vreg, rf_rd_idx      read address, zero when no read is issued
//   rf_rd_data                 read data, valid the cycle after rf_rd_en
//   elem_valid / elem_ready    element stream handshake
//   elem_data, elem_idx        element value and index
//   elem_last                  element carries index vlen-1
//   done                       one-cycle pulse when a request has completed
// ----------------------------------------------------------------------------
module vector_register_reader #(
    parameter int  VECTOR_REG_WIDTH = 64,
    parameter int  VECTOR_REG_DEPTH = 64,
    parameter int  NUM_VREGS        = 8,
    localparam int VREG_W           = $clog2(NUM_VREGS),
    localparam int IDX_W            = $clog2(VECTOR_REG_DEPTH),
    localparam int VLEN_W           = IDX_W + 1
) (
    input  logic                        clk,
    input  logic                        reset_n,

    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [VREG_W-1:0]           req_vreg,
    input  logic [VLEN_W-1:0]           req_vlen,

    output logic                        rf_rd_en,
    output logic [VREG_W-1:0]           rf_rd_vreg,
    output logic [IDX_W-1:0]            rf_rd_idx,
    input  logic [VECTOR_REG_WIDTH-1:0] rf_rd_data,

    output logic                        elem_valid,
    input  logic                        elem_ready,
    output logic [VECTOR_REG_WIDTH-1:0] elem_data,
    output logic [IDX_W-1:0]            elem_idx,
    output logic                        elem_last,
    output logic                        done
);

    // Return buffer size. It matches the credit limit, so one element can
    // be in each stage of the read pipeline and the stream keeps running
    // at full rate.
    localparam int FIFO_DEPTH = 3;

    typedef enum logic [0:0] {
        IDLE,
        STREAM
    } state_t;

    // ------------------------------------------------------------------
    // Request / sequencing state
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [VREG_W-1:0]   vreg_q, vreg_d;
    logic [VLEN_W-1:0]   vlen_q, vlen_d;
    logic [VLEN_W-1:0]   issue_idx_q, issue_idx_d;
    logic                done_q, done_d;

    // Read launched in the previous cycle; its data is on rf_rd_data now.
    logic                inflight_valid_q;
    logic [IDX_W-1:0]    inflight_idx_q;

    // Return FIFO (circular, 3 entries)
    logic [VECTOR_REG_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [IDX_W-1:0]            fifo_idx  [FIFO_DEPTH];
    logic [1:0]                  rd_ptr_q;
    logic [1:0]                  wr_ptr_q;
    logic [1:0]                  count_q;

    logic                accept;
    logic [2:0]          credits_used;
    logic                issue;
    logic                push;
    logic                pop;
    logic                last_xfer;
    logic [VLEN_W-1:0]   last_idx;

    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'(FIFO_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

    // ------------------------------------------------------------------
    // Handshakes and read issue
    // ------------------------------------------------------------------
    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    // Credits come from the occupancy at the start of the cycle. A pop in
    // the same cycle is not counted, which keeps the issue path short.
    assign credits_used = {1'b0, count_q} + {2'b00, inflight_valid_q};
    assign issue        = (state_q == STREAM)
                       && (issue_idx_q < vlen_q)
                       && (credits_used < 3'(FIFO_DEPTH));

    assign rf_rd_en   = issue;
    assign rf_rd_vreg = issue ? vreg_q : '0;
    assign rf_rd_idx  = issue ? issue_idx_q[IDX_W-1:0] : '0;

    // ------------------------------------------------------------------
    // Element stream, driven from the FIFO head
    // ------------------------------------------------------------------
    assign elem_valid = (count_q != 2'd0);
    assign elem_data  = elem_valid ? fifo_data[rd_ptr_q] : '0;
    assign elem_idx   = elem_valid ? fifo_idx[rd_ptr_q]  : '0;

    // Only evaluated in STREAM, where vlen_q is at least 1, so no underflow.
    assign last_idx  = vlen_q - VLEN_W'(1);
    assign elem_last = elem_valid && ({1'b0, elem_idx} == last_idx);

    assign push      = inflight_valid_q;
    assign pop       = elem_valid && elem_ready;
    assign last_xfer = pop && elem_last;

    assign done = done_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable gets its default before the case statement, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        vreg_d      = vreg_q;
        vlen_d      = vlen_q;
        issue_idx_d = issue_idx_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    vreg_d      = req_vreg;
                    vlen_d      = req_vlen;
                    issue_idx_d = '0;
                    if (req_vlen == '0) begin
                        // Empty vector: complete right away without any reads.
                        done_d = 1'b1;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end

            STREAM: begin
                if (issue) begin
                    // One bit wider than the element index, so it stops at
                    // DEPTH for a full-length vector and does not wrap to 0.
                    issue_idx_d = issue_idx_q + VLEN_W'(1);
                end
                if (last_xfer) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. All registers
    // then update together at the clock edge, whatever order the blocks run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            vreg_q      <= '0;
            vlen_q      <= '0;
            issue_idx_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vreg_q      <= vreg_d;
            vlen_q      <= vlen_d;
            issue_idx_q <= issue_idx_d;
            done_q      <= done_d;
        end
    end

    // A reset mid-stream clears this tag, so data returned for a read
    // abandoned by the reset is never written into the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_valid_q <= 1'b0;
            inflight_idx_q   <= '0;
        end else begin
            inflight_valid_q <= issue;
            inflight_idx_q   <= rf_rd_idx;
        end
    end

    // ------------------------------------------------------------------
    // Return FIFO control. The credit rule guarantees push never meets a
    // full FIFO, so no full check is needed here.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset. Its contents are never seen
    // while count_q is zero, because the outputs are forced to zero when the
    // FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= rf_rd_data;
            fifo_idx[wr_ptr_q]  <= inflight_idx_q;
        end
    end

endmodule

// File: doc/vector_register_reader.md
# vector_register_reader

Read-side streamer for the vector register file. It accepts a read request naming one vector register and a vector length. It then fetches elements 0..vlen-1 through the register file's 1-cycle-latency read port and presents them one per cycle on a valid/ready element stream toward the execution lanes. It sits between the vector issue logic and the lanes, and it is the read counterpart of the register-file write/reset path.

## Interface
- VECTOR_REG_WIDTH, 64, element width in bits
- VECTOR_REG_DEPTH, 64, elements per vector register
- NUM_VREGS, 8, number of vector registers (register select width = clog2(NUM_VREGS))
- clk  input  1  clock; all state changes on posedge
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  read request valid
- req_ready  output  1  block can accept a request
- req_vreg  input  clog2(NUM_VREGS)  vector register to read
- req_vlen  input  clog2(VECTOR_REG_DEPTH)+1  element count, 0..VECTOR_REG_DEPTH
- rf_rd_en  output  1  register file read strobe
- rf_rd_vreg  output  clog2(NUM_VREGS)  register select for the read
- rf_rd_idx  output  clog2(VECTOR_REG_DEPTH)  element index for the read
- rf_rd_data  input  VECTOR_REG_WIDTH  read data, valid the cycle after rf_rd_en
- elem_valid  output  1  element stream valid
- elem_ready  input  1  consumer accepts element
- elem_data  output  VECTOR_REG_WIDTH  element value
- elem_idx  output  clog2(VECTOR_REG_DEPTH)  element index
- elem_last  output  1  element is index vlen-1
- done  output  1  one-cycle pulse after the final element transfers, or after a vlen=0 request

## Operation
- FSM states: IDLE, STREAM.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch vreg and vlen.
  - If vlen==0: stay in IDLE and pulse done in the next cycle. No reads are issued and no elements are produced.
  - Otherwise go to STREAM with issue_idx=0.
- STREAM:
  - req_ready=0.
  - Issue a read when issue_idx<vlen and (buffer occupancy + in-flight read) < 3. The count is taken at the start of the cycle; a same-cycle pop is not subtracted.
  - A read drives rf_rd_en=1, rf_rd_vreg=latched vreg, rf_rd_idx=issue_idx. issue_idx then increments.
- rf_rd_en, rf_rd_vreg and rf_rd_idx are combinational from registered state. When rf_rd_en=0, rf_rd_vreg and rf_rd_idx are driven to 0.
- Return path:
  - rf_rd_data is captured into a 3-entry FIFO at the end of the cycle after the read strobe, tagged with its index.
  - The FIFO head drives elem_data, elem_idx and elem_valid.
  - elem_last = elem_valid && (elem_idx == vlen-1).
- Element ordering is strictly ascending, with no gaps and no duplicates.
- Transfer occurs when elem_valid&&elem_ready. Once asserted, elem_valid and elem_data hold stable until the transfer.
- When the element with elem_last transfers: go to IDLE next cycle and pulse done=1 for exactly that next cycle.
- The buffer cannot overflow: the credit rule guarantees at most 3 elements are buffered or in flight.
- vlen==VECTOR_REG_DEPTH: issue_idx reaches 64 and stops. Its counter is clog2(DEPTH)+1 bits wide, so it does not wrap.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - state=IDLE, FIFO empty, counters 0.
  - Outputs: req_ready=1, rf_rd_en=0, rf_rd_vreg=0, rf_rd_idx=0, elem_valid=0, elem_data=0, elem_idx=0, elem_last=0, done=0.
- Reset asserted mid-stream: the stream is abandoned immediately. Any in-flight read data is discarded and no done pulse occurs.
- Latency, with the request accepted in cycle 0:
  - First rf_rd_en in cycle 1.
  - rf_rd_data for element 0 presented in cycle 2.
  - elem_valid for element 0 in cycle 3.
- Throughput: 1 element/cycle when elem_ready is held high. For vlen=N, the last element transfers in cycle N+2 and done pulses in cycle N+3.
- Back-to-back: req_ready rises in the same cycle as the done pulse, so the next request is accepted no earlier than that cycle.
- Backpressure: while elem_ready=0, reads continue until 3 credits are used, then rf_rd_en stays 0. Reads resume the cycle after a pop.
- done and a new request acceptance may occur in the same cycle.

## Test plan
- Reset, then request vreg=3, vlen=64, elem_ready=1, with register contents data=(vreg<<8)|idx:
  - elem_valid first in cycle 3.
  - 64 consecutive transfers with idx 0..63 and data 0x300..0x33F.
  - elem_last only on idx 63; done single pulse in cycle 67.
- Request vlen=0 → no rf_rd_en and no elem_valid; done pulses exactly once the cycle after acceptance; req_ready stays 1.
- vlen=8 with elem_ready low for cycles 3-10:
  - exactly 3 reads are issued, then rf_rd_en=0;
  - elem_data and elem_idx=0 stay stable while stalled;
  - after release, idx 0..7 arrive in order with no loss.
- Random elem_ready (50%) with vlen=1, 2, 3, 37 → the sequence matches a reference model; FIFO occupancy plus in-flight never exceeds 3.
- Back-to-back requests vlen=4 on vreg=1 then vreg=2, with the second req_valid held → second accepted in the cycle of the first done; streams do not interleave.
- Assert reset_n=0 while in STREAM at elem_idx=5 of 20 → all outputs take their reset values immediately; no done pulse; a new request after release streams from idx 0.
